// File: rtl/mul_div_unit_if.sv
// Request/result bundle between the EX stage and the multiply/divide unit.
// The master drives operations and HI/LO writes; the slave returns busy and HI/LO.
interface mul_div_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] rs;
  logic [WIDTH-1:0] rt;
  logic             hilo_we;
  logic             hilo_sel;
  logic             flush;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, rs, rt, hilo_we, hilo_sel, flush,
    input  busy, hi, lo
  );

  modport slave (
    input  start, op, rs, rt, hilo_we, hilo_sel, flush,
    output busy, hi, lo
  );
endinterface

// File: rtl/mul_div_unit.sv
// Sequential multiply / multiply-accumulate / divide unit with HI/LO registers.
// The result is computed at the accepting edge and committed after a fixed latency.
module mul_div_unit #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic         clk,
  input  logic         reset,
  mul_div_unit_if.slave bus
);

  localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC) + 1;
  localparam int unsigned DW      = 2 * WIDTH;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           r_state;
  logic             r_busy;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_res_hi;
  logic [WIDTH-1:0] r_res_lo;

  logic             w_op_rsvd;
  logic             w_is_div;
  logic             w_is_mac;
  logic             w_signed;
  logic             w_accept;
  logic [DW-1:0]    w_a_ext;
  logic [DW-1:0]    w_b_ext;
  logic [DW-1:0]    w_prod;
  logic [DW-1:0]    w_mul_res;
  logic             w_a_neg;
  logic             w_b_neg;
  logic             w_b_zero;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH-1:0] w_q_mag;
  logic [WIDTH-1:0] w_r_mag;
  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_r;

  assign w_op_rsvd = (bus.op[2:1] == 2'b11);
  assign w_is_div  = (bus.op[2:1] == 2'b01);
  assign w_is_mac  = bus.op[2];
  assign w_signed  = bus.op[0];
  assign w_accept  = bus.start && !r_busy && !bus.flush && !w_op_rsvd;

  // Sign/zero-extend to 2*WIDTH so the truncated product is correct for both signednesses.
  assign w_a_ext   = w_signed ? {{WIDTH{bus.rs[WIDTH-1]}}, bus.rs} : {{WIDTH{1'b0}}, bus.rs};
  assign w_b_ext   = w_signed ? {{WIDTH{bus.rt[WIDTH-1]}}, bus.rt} : {{WIDTH{1'b0}}, bus.rt};
  assign w_prod    = w_a_ext * w_b_ext;
  assign w_mul_res = w_is_mac ? ({r_hi, r_lo} + w_prod) : w_prod;

  // Magnitude division; -2^(W-1) / -1 falls out as quotient 2^(W-1), remainder 0.
  assign w_a_neg  = w_signed & bus.rs[WIDTH-1];
  assign w_b_neg  = w_signed & bus.rt[WIDTH-1];
  assign w_b_zero = (bus.rt == '0);
  assign w_a_mag  = w_a_neg ? WIDTH'(-bus.rs) : bus.rs;
  assign w_b_mag  = w_b_zero ? WIDTH'(1) : (w_b_neg ? WIDTH'(-bus.rt) : bus.rt);
  assign w_q_mag  = w_a_mag / w_b_mag;
  assign w_r_mag  = w_a_mag % w_b_mag;
  assign w_q      = (w_a_neg ^ w_b_neg) ? WIDTH'(-w_q_mag) : w_q_mag;
  assign w_r      = w_a_neg ? WIDTH'(-w_r_mag) : w_r_mag;

  assign bus.busy = r_busy;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;

  // Control FSM, latency counter, pending result and HI/LO.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_busy   <= 1'b0;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_res_hi <= '0;
      r_res_lo <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_is_div) begin
              r_res_hi <= w_b_zero ? bus.rs : w_r;
              r_res_lo <= w_b_zero ? {WIDTH{1'b1}} : w_q;
              r_cnt    <= CNT_W'(DIV_CYCLES);
            end else begin
              r_res_hi <= w_mul_res[DW-1:WIDTH];
              r_res_lo <= w_mul_res[WIDTH-1:0];
              r_cnt    <= CNT_W'(MULT_CYCLES);
            end
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end else if (bus.hilo_we) begin
            if (bus.hilo_sel) r_hi <= bus.rs;
            else              r_lo <= bus.rs;
          end
        end
        S_RUN: begin
          if (bus.flush) begin
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else if (r_cnt == CNT_W'(1)) begin
            r_hi    <= r_res_hi;
            r_lo    <= r_res_lo;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_cnt   <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: latency, arithmetic results, HI/LO writes,
// ignored requests, flush and mid-operation reset.
module tb_mul_div_unit;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned MULT  = 5;
  localparam int unsigned DIV   = 10;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mul_div_unit_if #(.WIDTH(WIDTH)) bus ();

  mul_div_unit #(
    .WIDTH      (WIDTH),
    .MULT_CYCLES(MULT),
    .DIV_CYCLES (DIV)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch op at the next edge, then verify busy for exactly n cycles and HI/LO held until commit.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int n);
    logic [31:0] pre_hi;
    logic [31:0] pre_lo;
    pre_hi     = bus.hi;
    pre_lo     = bus.lo;
    bus.start  = 1'b1;
    bus.op     = op;
    bus.rs     = a;
    bus.rt     = b;
    tick();
    bus.start  = 1'b0;
    for (int i = 0; i < n; i++) begin
      check({tag, " busy"}, 64'(bus.busy), 64'(1));
      check({tag, " hold"}, {bus.hi, bus.lo}, {pre_hi, pre_lo});
      tick();
    end
    check({tag, " done"}, 64'(bus.busy), 64'(0));
  endtask

  initial begin
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.op       = 3'd0;
    bus.rs       = '0;
    bus.rt       = '0;
    bus.hilo_we  = 1'b0;
    bus.hilo_sel = 1'b0;
    bus.flush    = 1'b0;
    tick();
    tick();
    check("reset hilo", {bus.hi, bus.lo}, 64'h0);
    check("reset busy", 64'(bus.busy), 64'(0));
    reset = 1'b0;

    // -3 * 5 = -15
    run_op("mult", 3'b001, 32'hFFFF_FFFD, 32'd5, MULT);
    check("mult hilo", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFF1);

    run_op("divu", 3'b010, 32'd7, 32'd2, DIV);
    check("divu hilo", {bus.hi, bus.lo}, {32'd1, 32'd3});
    run_op("div", 3'b011, 32'hFFFF_FFF9, 32'd2, DIV);
    check("div hilo", {bus.hi, bus.lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});

    bus.hilo_we = 1'b1; bus.hilo_sel = 1'b0; bus.rs = 32'd10;
    tick();
    bus.hilo_sel = 1'b1; bus.rs = 32'd0;
    tick();
    bus.hilo_we = 1'b0;
    check("mthi/mtlo", {bus.hi, bus.lo}, {32'd0, 32'd10});
    run_op("madd", 3'b101, 32'd3, 32'd4, MULT);
    check("madd hilo", {bus.hi, bus.lo}, {32'd0, 32'h16});
    // 0x16 + 0xFFFFFFFF*2 = 0x2_0000_0014
    run_op("maddu", 3'b100, 32'hFFFF_FFFF, 32'd2, MULT);
    check("maddu hilo", {bus.hi, bus.lo}, {32'd2, 32'h14});
    // 0x2_0000_0014 + (-2 * 3) = 0x2_0000_000E
    run_op("madd neg", 3'b101, 32'hFFFF_FFFE, 32'd3, MULT);
    check("madd neg hilo", {bus.hi, bus.lo}, {32'd2, 32'h0E});

    run_op("div0", 3'b011, 32'h1234, 32'd0, DIV);
    check("div0 hilo", {bus.hi, bus.lo}, {32'h1234, 32'hFFFF_FFFF});
    run_op("divovf", 3'b011, 32'h8000_0000, 32'hFFFF_FFFF, DIV);
    check("divovf hilo", {bus.hi, bus.lo}, {32'h0, 32'h8000_0000});
    run_op("divu0", 3'b010, 32'h55, 32'd0, DIV);
    check("divu0 hilo", {bus.hi, bus.lo}, {32'h55, 32'hFFFF_FFFF});

    // Reserved op while idle changes nothing.
    bus.start = 1'b1; bus.op = 3'b110; bus.rs = 32'd9; bus.rt = 32'd9;
    tick();
    bus.start = 1'b0;
    check("rsvd busy", 64'(bus.busy), 64'(0));
    check("rsvd hilo", {bus.hi, bus.lo}, {32'h55, 32'hFFFF_FFFF});

    // Start together with hilo_we: the write is dropped.
    bus.hilo_we = 1'b1; bus.hilo_sel = 1'b1;
    run_op("start+we", 3'b000, 32'd2, 32'd3, MULT);
    bus.hilo_we = 1'b0;
    check("start+we hilo", {bus.hi, bus.lo}, {32'd0, 32'd6});

    // In-flight multu: second start and write ignored, then flushed.
    bus.start = 1'b1; bus.op = 3'b000; bus.rs = 32'h10; bus.rt = 32'h10;
    tick();
    bus.op = 3'b010; bus.rs = 32'd9; bus.rt = 32'd3;
    tick();
    bus.start = 1'b0;
    bus.hilo_we = 1'b1; bus.hilo_sel = 1'b0; bus.rs = 32'hAB;
    tick();
    bus.hilo_we = 1'b0;
    check("flush pre busy", 64'(bus.busy), 64'(1));
    check("busy we hilo", {bus.hi, bus.lo}, {32'd0, 32'd6});
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("flush busy", 64'(bus.busy), 64'(0));
    check("flush hilo", {bus.hi, bus.lo}, {32'd0, 32'd6});
    for (int i = 0; i < DIV + 2; i++) tick();
    check("flush late busy", 64'(bus.busy), 64'(0));
    check("flush late hilo", {bus.hi, bus.lo}, {32'd0, 32'd6});

    // Flush while idle blocks a same-cycle start.
    bus.flush = 1'b1; bus.start = 1'b1; bus.op = 3'b000; bus.rs = 32'd3; bus.rt = 32'd3;
    tick();
    bus.flush = 1'b0; bus.start = 1'b0;
    check("idle flush busy", 64'(bus.busy), 64'(0));
    for (int i = 0; i < MULT + 1; i++) tick();
    check("idle flush hilo", {bus.hi, bus.lo}, {32'd0, 32'd6});

    // Reset at cycle 2 of a div.
    bus.start = 1'b1; bus.op = 3'b011; bus.rs = 32'd100; bus.rt = 32'd7;
    tick();
    bus.start = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    check("midreset busy", 64'(bus.busy), 64'(0));
    check("midreset hilo", {bus.hi, bus.lo}, 64'h0);
    reset = 1'b0;
    for (int i = 0; i < DIV + 2; i++) tick();
    check("midreset late busy", 64'(bus.busy), 64'(0));
    check("midreset late hilo", {bus.hi, bus.lo}, 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
